// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter (edge- or
// center-aligned) drives CHANNELS compare outputs with double-buffered
// duty registers, per-channel enable/polarity and a period-start strobe.
module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [WIDTH-1:0]    period,
  input  logic                center_mode,
  input  logic [CHANNELS-1:0] ch_enable,
  input  logic [CHANNELS-1:0] polarity,
  input  logic                wr_en,
  input  logic [CH_BITS-1:0]  wr_chan,
  input  logic [WIDTH-1:0]    wr_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  logic [WIDTH-1:0]    cnt;
  logic                dir_down;
  logic [WIDTH-1:0]    active_period;
  logic                active_mode;
  logic [WIDTH-1:0]    active_duty [CHANNELS];
  logic [WIDTH-1:0]    shadow_duty [CHANNELS];

  logic                boundary;
  logic [WIDTH-1:0]    eff_period;
  logic                eff_mode;
  logic [WIDTH-1:0]    eff_duty [CHANNELS];
  logic [CHANNELS-1:0] raw;
  logic [WIDTH-1:0]    cnt_next;
  logic                down_next;

  // At a boundary the freshly loaded settings already govern this cycle,
  // so compare and next-count use the incoming values rather than the old ones.
  always_comb begin
    boundary   = enable && (cnt == '0) && !dir_down;
    eff_period = boundary ? period : active_period;
    eff_mode   = boundary ? center_mode : active_mode;
    raw        = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      eff_duty[i] = boundary ? shadow_duty[i] : active_duty[i];
      raw[i]      = ch_enable[i] && (cnt < eff_duty[i]);
    end
    cnt_next  = cnt;
    down_next = dir_down;
    if (eff_period == '0) begin
      cnt_next  = '0;
      down_next = 1'b0;
    end else if (!eff_mode) begin
      cnt_next  = (cnt >= eff_period) ? '0 : cnt + 1'b1;
      down_next = 1'b0;
    end else if (!dir_down) begin
      if (cnt >= eff_period) begin
        cnt_next  = eff_period - 1'b1;
        down_next = (eff_period != WIDTH'(1));
      end else begin
        cnt_next  = cnt + 1'b1;
        down_next = 1'b0;
      end
    end else begin
      cnt_next  = cnt - 1'b1;
      down_next = (cnt != WIDTH'(1));
    end
  end

  // Shadow duty registers written through the write port; out-of-range channels match nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) shadow_duty[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_chan == CH_BITS'(i)) shadow_duty[i] <= wr_duty;
      end
    end
  end

  // Counter, active settings and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      dir_down      <= 1'b0;
      active_period <= '0;
      active_mode   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) active_duty[i] <= '0;
      pwm_out       <= '0;
      period_start  <= 1'b0;
    end else if (!enable) begin
      cnt           <= '0;
      dir_down      <= 1'b0;
      active_period <= period;
      active_mode   <= center_mode;
      for (int i = 0; i < CHANNELS; i++) active_duty[i] <= shadow_duty[i];
      pwm_out       <= polarity;
      period_start  <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      dir_down     <= down_next;
      pwm_out      <= raw ^ polarity;
      period_start <= boundary;
      if (boundary) begin
        active_period <= period;
        active_mode   <= center_mode;
        for (int i = 0; i < CHANNELS; i++) active_duty[i] <= shadow_duty[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi: directed scenarios followed by random traffic,
// all checked cycle by cycle against a phase-based reference model.
module tb_pwm_multi;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int CH_BITS  = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                enable = 1'b0;
  logic [WIDTH-1:0]    period = '0;
  logic                center_mode = 1'b0;
  logic [CHANNELS-1:0] ch_enable = '0;
  logic [CHANNELS-1:0] polarity = '0;
  logic                wr_en = 1'b0;
  logic [CH_BITS-1:0]  wr_chan = '0;
  logic [WIDTH-1:0]    wr_duty = '0;
  logic [CHANNELS-1:0] pwm_out;
  logic                period_start;

  int pass_count  = 0;
  int check_count = 0;

  // Reference model: position within the period plus the settings it runs with.
  int                  m_k = 0;
  int                  m_p = 0;
  bit                  m_mode = 1'b0;
  int                  m_active [CHANNELS];
  int                  m_shadow [CHANNELS];
  logic [CHANNELS-1:0] exp_pwm = '0;
  logic                exp_ps = 1'b0;

  pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_BITS(CH_BITS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period),
    .center_mode(center_mode), .ch_enable(ch_enable), .polarity(polarity),
    .wr_en(wr_en), .wr_chan(wr_chan), .wr_duty(wr_duty),
    .pwm_out(pwm_out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  function automatic int period_len(int p, bit mode);
    if (p == 0) return 1;
    return mode ? 2 * p : p + 1;
  endfunction

  function automatic int cnt_at(int k, int p, bit mode);
    if (!mode || k <= p) return k;
    return 2 * p - k;
  endfunction

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic applyStimulus();
    int c;
    if (rst) begin
      m_k = 0; m_p = 0; m_mode = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin m_active[i] = 0; m_shadow[i] = 0; end
      exp_pwm = '0; exp_ps = 1'b0;
    end else begin
      if (!enable) begin
        for (int i = 0; i < CHANNELS; i++) m_active[i] = m_shadow[i];
        m_p = int'(period); m_mode = center_mode; m_k = 0;
        exp_pwm = polarity; exp_ps = 1'b0;
      end else begin
        if (m_k == 0) begin
          for (int i = 0; i < CHANNELS; i++) m_active[i] = m_shadow[i];
          m_p = int'(period); m_mode = center_mode;
        end
        c = cnt_at(m_k, m_p, m_mode);
        for (int i = 0; i < CHANNELS; i++)
          exp_pwm[i] = (ch_enable[i] && (c < m_active[i])) ^ polarity[i];
        exp_ps = (m_k == 0);
        m_k = (m_k + 1) % period_len(m_p, m_mode);
      end
      if (wr_en && int'(wr_chan) < CHANNELS) m_shadow[int'(wr_chan)] = int'(wr_duty);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string tag);
    check_count++;
    assert (pwm_out === exp_pwm) pass_count++;
    else $error("[TB] FAIL %s pwm_out got %b expected %b", tag, pwm_out, exp_pwm);
    check_count++;
    assert (period_start === exp_ps) pass_count++;
    else $error("[TB] FAIL %s period_start got %b expected %b", tag, period_start, exp_ps);
  endtask

  task automatic checkBit(string tag, logic got, logic want);
    check_count++;
    assert (got === want) pass_count++;
    else $error("[TB] FAIL %s got %b expected %b", tag, got, want);
  endtask

  task automatic run(string tag, int n);
    for (int j = 0; j < n; j++) begin
      applyStimulus();
      checkOutput(tag);
    end
  endtask

  task automatic writeDuty(string tag, int ch, int d);
    wr_en = 1'b1; wr_chan = CH_BITS'(ch); wr_duty = WIDTH'(d);
    applyStimulus();
    checkOutput(tag);
    wr_en = 1'b0;
  endtask

  task automatic waitBoundary(string tag);
    int guard = 0;
    while (m_k != 0 && guard < 40) begin
      applyStimulus();
      checkOutput(tag);
      guard++;
    end
    check_count++;
    assert (m_k == 0) pass_count++;
    else $error("[TB] FAIL %s boundary wait timed out k=%0d expected 0", tag, m_k);
  endtask

  initial begin
    int pat_edge [5]   = '{1, 1, 0, 0, 0};
    int pat_ch3 [5]    = '{0, 0, 0, 1, 1};
    int pat_center [8] = '{1, 1, 0, 0, 0, 0, 0, 1};

    $display("[TB] reset");
    rst = 1'b1;
    run("reset", 2);
    rst = 1'b0;

    $display("[TB] edge basic");
    period = 8'd4; ch_enable = 4'hF; polarity = 4'b1000;
    writeDuty("edge_wr", 0, 2);
    writeDuty("edge_wr", 1, 0);
    writeDuty("edge_wr", 2, 5);
    writeDuty("edge_wr", 3, 3);
    run("edge_idle", 1);
    enable = 1'b1;
    for (int j = 0; j < 15; j++) begin
      applyStimulus();
      checkOutput("edge_run");
      checkBit("edge_ch0", pwm_out[0], logic'(pat_edge[j % 5]));
      checkBit("edge_ch3", pwm_out[3], logic'(pat_ch3[j % 5]));
      checkBit("edge_ps", period_start, logic'(j % 5 == 0));
    end

    $display("[TB] center mode");
    enable = 1'b0; center_mode = 1'b1; polarity = '0;
    writeDuty("ctr_wr", 0, 2);
    enable = 1'b1;
    for (int j = 0; j < 16; j++) begin
      applyStimulus();
      checkOutput("ctr_run");
      checkBit("ctr_ch0", pwm_out[0], logic'(pat_center[j % 8]));
      checkBit("ctr_ps", period_start, logic'(j % 8 == 0));
    end

    $display("[TB] double buffering");
    enable = 1'b0; center_mode = 1'b0; period = 8'd9;
    writeDuty("dbuf_wr", 0, 3);
    enable = 1'b1;
    run("dbuf_run", 5);
    writeDuty("dbuf_mid", 0, 7);
    run("dbuf_run", 20);
    waitBoundary("dbuf_wait");
    writeDuty("dbuf_bnd", 0, 1);
    run("dbuf_run", 22);

    $display("[TB] period change");
    run("per_run", 4);
    period = 8'd3;
    run("per_run", 20);

    $display("[TB] enable and polarity");
    ch_enable = 4'b1101; polarity = 4'b0110;
    run("chan_off", 6);
    enable = 1'b0;
    run("glob_off", 3);
    enable = 1'b1;
    applyStimulus();
    checkOutput("reenable");
    checkBit("reenable_ps", period_start, 1'b1);
    run("reenable", 8);

    $display("[TB] reset mid-run");
    rst = 1'b1;
    applyStimulus();
    checkOutput("rst_mid");
    checkBit("rst_ps", period_start, 1'b0);
    rst = 1'b0; polarity = '0; ch_enable = 4'hF;
    run("post_rst", 8);
    checkBit("post_rst_zero", |pwm_out, 1'b0);

    $display("[TB] zero period and bad channel");
    writeDuty("p0_wr", 1, 2);
    period = 8'd0;
    enable = 1'b0;
    run("p0_idle", 1);
    enable = 1'b1;
    for (int j = 0; j < 6; j++) begin
      applyStimulus();
      checkOutput("p0_run");
      checkBit("p0_ps", period_start, 1'b1);
    end
    writeDuty("badch_wr", CHANNELS, 9);
    writeDuty("badch_wr", 7, 9);
    period = 8'd5;
    run("badch_run", 14);

    $display("[TB] random traffic");
    for (int j = 0; j < 600; j++) begin
      rst         = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 9) == 0) period = WIDTH'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) center_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) ch_enable = CHANNELS'($urandom);
      if ($urandom_range(0, 15) == 0) polarity = CHANNELS'($urandom);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_chan = CH_BITS'($urandom_range(0, 5));
      wr_duty = WIDTH'($urandom_range(0, 15));
      applyStimulus();
      checkOutput("random");
    end
    rst = 1'b0; wr_en = 1'b0;

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
